// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART Tx byte arbiter.
// State encoding is fixed: IDLE=0, LOAD=1, WAIT=2.
package uart_tx_arbiter_pkg;

  localparam int unsigned DEF_N_REQ       = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 65535;
  localparam int unsigned DEF_TO_W        = 16;
  localparam int unsigned BYTE_W          = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_grant
);

  int unsigned idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_grant && req[ID_W'(idx)]) begin
        any_grant               = 1'b1;
        grant_idx               = ID_W'(idx);
        grant_oh[ID_W'(idx)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART Tx between N_REQ byte sources, one byte per grant.
// Optional WAIT watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = DEF_N_REQ,
  parameter int unsigned ID_W        = $clog2(N_REQ),
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned TO_W        = DEF_TO_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*BYTE_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [BYTE_W-1:0]        tx_d,
  output logic                     tx_en,
  input  logic                     tx_complete,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     err_timeout
);

  if (N_REQ < 2 || N_REQ > 8 || ID_W != $clog2(N_REQ) || TO_W < 1 || TO_W > 32 ||
      TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter combination");
  end

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [BYTE_W-1:0]   tx_d_nxt, sel_byte;
  logic [ID_W-1:0]     grant_id_nxt;
  logic [N_REQ-1:0]    grant_oh;
  logic [ID_W-1:0]     grant_idx;
  logic                any_grant;
  logic                to_expire;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // One-hot grant makes the byte select a simple AND-OR.
  always_comb begin
    sel_byte = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sel_byte = sel_byte | (req_data[k*BYTE_W +: BYTE_W] & {BYTE_W{grant_oh[k]}});
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            err_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    tx_d_nxt     = tx_d;
    grant_id_nxt = grant_id;
    req_ready    = '0;
    to_expire    = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_nxt   = to_cnt;
    err_nxt      = err_timeout;
`endif
    case (state)
      IDLE: begin
        if (any_grant && !rst) begin
          req_ready    = grant_oh;
          tx_d_nxt     = sel_byte;
          grant_id_nxt = grant_idx;
          rr_ptr_nxt   = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
          state_nxt    = LOAD;
        end
      end
      LOAD: begin
        state_nxt = WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
        to_cnt_nxt = '0;
`endif
      end
      WAIT: begin
        if (tx_complete) begin
          state_nxt = IDLE;
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          // Expire on the TIMEOUT_CYC-th WAIT cycle without completion.
          to_expire = (32'(to_cnt) + 1 == TIMEOUT_CYC);
          if (to_expire) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            to_cnt_nxt = to_cnt + TO_W'(1);
          end
`else
          to_expire = 1'b0;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      tx_d     <= '0;
      grant_id <= '0;
      tx_en    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      tx_d     <= tx_d_nxt;
      grant_id <= grant_id_nxt;
      tx_en    <= (state_nxt == LOAD);
      busy     <= (state_nxt != IDLE);
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      to_cnt      <= to_cnt_nxt;
      err_timeout <= err_nxt;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule
